// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_EXC    = 2'd2;
    localparam logic [1:0] PC_HOLD   = 2'd3;

    localparam int          DEF_MUL_LATENCY = 5;
    localparam logic [31:0] DEF_EXC_VECTOR  = 32'h0000_2000;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Event inputs from the pipeline stages and the stall/flush/PC-select controls back to them.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  d_valid;
    logic [REG_ADDR_W-1:0] d_rs1;
    logic [REG_ADDR_W-1:0] d_rs2;
    logic                  d_use_rs1;
    logic                  d_use_rs2;
    logic                  d_is_mul;
    logic                  e_valid;
    logic [REG_ADDR_W-1:0] e_rd;
    logic                  e_is_load;
    logic                  e_branch_taken;
    logic                  icache_miss;
    logic                  dcache_miss;
    logic                  w_exception;
    logic                  sb_empty;

    logic                  stall_fd;
    logic                  flush_fd;
    logic                  stall_de;
    logic                  flush_de;
    logic                  stall_em;
    logic                  flush_em;
    logic [1:0]            pc_sel;
    logic                  mul_busy;
    logic [1:0]            exc_state;

    // master = pipeline side, slave = controller
    modport master (
        output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_is_mul,
               e_valid, e_rd, e_is_load, e_branch_taken,
               icache_miss, dcache_miss, w_exception, sb_empty,
        input  stall_fd, flush_fd, stall_de, flush_de, stall_em, flush_em,
               pc_sel, mul_busy, exc_state
    );

    modport slave (
        input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_is_mul,
               e_valid, e_rd, e_is_load, e_branch_taken,
               icache_miss, dcache_miss, w_exception, sb_empty,
        output stall_fd, flush_fd, stall_de, flush_de, stall_em, flush_em,
               pc_sel, mul_busy, exc_state
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in E whose result the instruction in D reads.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_d_valid,
    input  logic [REG_ADDR_W-1:0] i_d_rs1,
    input  logic [REG_ADDR_W-1:0] i_d_rs2,
    input  logic                  i_d_use_rs1,
    input  logic                  i_d_use_rs2,
    input  logic                  i_e_valid,
    input  logic [REG_ADDR_W-1:0] i_e_rd,
    input  logic                  i_e_is_load,
    output logic                  o_load_use
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_d_use_rs1 && (i_d_rs1 == i_e_rd);
    assign w_rs2_hit  = i_d_use_rs2 && (i_d_rs2 == i_e_rd);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_load_use = i_d_valid && i_e_valid && i_e_is_load && (i_e_rd != '0)
                        && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush decode,
// multiply occupancy counter and the exception drain/redirect FSM.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int          WORD_SIZE   = 32,
    parameter int          REG_ADDR_W  = 5,
    parameter int          MUL_LATENCY = DEF_MUL_LATENCY,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);
    localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    exc_state_t       r_state;
    logic [CNT_W-1:0] r_mul_cnt;
    logic             w_load_use;
    logic             w_mul_busy;
    logic             w_mul_issue;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .i_d_valid   (bus.d_valid),
        .i_d_rs1     (bus.d_rs1),
        .i_d_rs2     (bus.d_rs2),
        .i_d_use_rs1 (bus.d_use_rs1),
        .i_d_use_rs2 (bus.d_use_rs2),
        .i_e_valid   (bus.e_valid),
        .i_e_rd      (bus.e_rd),
        .i_e_is_load (bus.e_is_load),
        .o_load_use  (w_load_use)
    );

    assign w_mul_busy    = (r_mul_cnt != '0);
    assign bus.mul_busy  = w_mul_busy;
    assign bus.exc_state = r_state;

    always_comb begin
        bus.stall_fd = 1'b0;
        bus.flush_fd = 1'b0;
        bus.stall_de = 1'b0;
        bus.flush_de = 1'b0;
        bus.stall_em = 1'b0;
        bus.flush_em = 1'b0;
        bus.pc_sel   = PC_SEQ;
        if (reset) begin
            bus.flush_fd = 1'b1;
            bus.flush_de = 1'b1;
            bus.flush_em = 1'b1;
            bus.pc_sel   = PC_HOLD;
        end else begin
            case (r_state)
                DRAIN: begin
                    bus.flush_fd = 1'b1;
                    bus.flush_de = 1'b1;
                    bus.flush_em = 1'b1;
                    bus.pc_sel   = PC_HOLD;
                end
                REDIRECT: begin
                    bus.flush_fd = 1'b1;
                    bus.pc_sel   = PC_EXC;
                end
                default: begin
                    if (bus.dcache_miss) begin
                        bus.stall_fd = 1'b1;
                        bus.stall_de = 1'b1;
                        bus.stall_em = 1'b1;
                        bus.pc_sel   = PC_HOLD;
                    end else if (bus.e_branch_taken) begin
                        bus.flush_fd = 1'b1;
                        bus.flush_de = 1'b1;
                        bus.pc_sel   = PC_BRANCH;
                    end else if (w_mul_busy) begin
                        bus.stall_fd = 1'b1;
                        bus.stall_de = 1'b1;
                        bus.flush_em = 1'b1;
                        bus.pc_sel   = PC_HOLD;
                    end else if (w_load_use) begin
                        bus.stall_fd = 1'b1;
                        bus.flush_de = 1'b1;
                        bus.pc_sel   = PC_HOLD;
                    end else if (bus.icache_miss) begin
                        bus.flush_fd = 1'b1;
                        bus.pc_sel   = PC_HOLD;
                    end
                end
            endcase
        end
    end

    assign w_mul_issue = bus.d_valid && bus.d_is_mul && !bus.stall_fd && !bus.flush_de;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_mul_cnt <= '0;
        end else begin
            case (r_state)
                DRAIN: begin
                    r_mul_cnt <= '0;
                    if (bus.sb_empty && !bus.dcache_miss) r_state <= REDIRECT;
                end
                REDIRECT: begin
                    r_mul_cnt <= '0;
                    r_state   <= RUN;
                end
                default: begin
                    // an exception outranks everything, including a frozen multiply
                    if (bus.w_exception) begin
                        r_state   <= DRAIN;
                        r_mul_cnt <= '0;
                    end else if (!bus.dcache_miss) begin
                        if (w_mul_issue)     r_mul_cnt <= MUL_LOAD;
                        else if (w_mul_busy) r_mul_cnt <= r_mul_cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the hazard rules.
module tb_pipeline_ctrl;
    localparam int ML = 5;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();

    pipeline_ctrl #(.WORD_SIZE(32), .REG_ADDR_W(5), .MUL_LATENCY(ML),
                    .EXC_VECTOR(32'h0000_2000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (actual still running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.d_valid = 0; bus.d_rs1 = 0; bus.d_rs2 = 0; bus.d_use_rs1 = 0; bus.d_use_rs2 = 0;
        bus.d_is_mul = 0; bus.e_valid = 0; bus.e_rd = 0; bus.e_is_load = 0;
        bus.e_branch_taken = 0; bus.icache_miss = 0; bus.dcache_miss = 0;
        bus.w_exception = 0; bus.sb_empty = 1;
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {bus.stall_fd, bus.flush_fd, bus.stall_de, bus.flush_de,
                bus.stall_em, bus.flush_em, bus.pc_sel};
    endfunction

    task automatic test_reset();
        clr();
        bus.dcache_miss = 1; bus.e_branch_taken = 1;
        reset = 1;
        step();
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b0101_0111) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", ctrl_vec(), 8'b0101_0111);
        end
        step();
        reset = 0; clr();
        #1;
        n_chk++;
        if (bus.exc_state !== 2'd0 || bus.mul_busy !== 1'b0 || bus.pc_sel !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got exc=%0d busy=%0b pc=%0d want 0 0 0",
                               bus.exc_state, bus.mul_busy, bus.pc_sel);
        end
        step();
    endtask

    task automatic test_load_use();
        clr();
        bus.e_valid = 1; bus.e_is_load = 1; bus.e_rd = 5;
        bus.d_valid = 1; bus.d_rs1 = 5; bus.d_use_rs1 = 1;
        #1;
        n_chk++;
        if (bus.stall_fd !== 1 || bus.flush_de !== 1 || bus.pc_sel !== 2'd3 || bus.stall_de !== 0) begin
            n_fail++; $display("FAIL load_use_hit: got %b want stall_fd=1 flush_de=1 pc=3", ctrl_vec());
        end
        step();
        bus.e_valid = 0; bus.e_is_load = 0;
        #1;
        n_chk++;
        if (bus.stall_fd !== 0 || bus.pc_sel !== 2'd0) begin
            n_fail++; $display("FAIL load_use_release: got %b want %b", ctrl_vec(), 8'b0);
        end
        step();
        bus.e_valid = 1; bus.e_is_load = 1; bus.e_rd = 0; bus.d_rs1 = 0;
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b0) begin
            n_fail++; $display("FAIL load_use_x0: got %b want %b", ctrl_vec(), 8'b0);
        end
        bus.e_rd = 7; bus.d_rs1 = 3; bus.d_use_rs2 = 1; bus.d_rs2 = 7;
        #1;
        n_chk++;
        if (bus.stall_fd !== 1 || bus.flush_de !== 1) begin
            n_fail++; $display("FAIL load_use_rs2: got %b want stall_fd=1 flush_de=1", ctrl_vec());
        end
        step();
    endtask

    task automatic test_mul();
        int busy, sfd;
        clr();
        bus.d_valid = 1; bus.d_is_mul = 1;
        #1;
        n_chk++;
        if (bus.mul_busy !== 0 || bus.stall_fd !== 0) begin
            n_fail++; $display("FAIL mul_issue: got busy=%0b stall_fd=%0b want 0 0", bus.mul_busy, bus.stall_fd);
        end
        step();
        bus.d_is_mul = 0;
        busy = 0; sfd = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.mul_busy) busy++;
            if (bus.stall_fd) sfd++;
            step();
        end
        n_chk++;
        if (busy != ML - 1 || sfd != ML - 1) begin
            n_fail++; $display("FAIL mul_length: got busy=%0d stall=%0d want %0d %0d", busy, sfd, ML-1, ML-1);
        end
        bus.d_is_mul = 1;
        step();
        bus.d_is_mul = 0;
        busy = 0;
        for (int i = 0; i < 12; i++) begin
            bus.dcache_miss = (i == 1 || i == 2);
            #1;
            if (bus.mul_busy) busy++;
            step();
        end
        bus.dcache_miss = 0;
        n_chk++;
        if (busy != ML + 1) begin
            n_fail++; $display("FAIL mul_frozen_length: got %0d want %0d", busy, ML + 1);
        end
    endtask

    task automatic test_branch_vs_loaduse();
        clr();
        bus.e_valid = 1; bus.e_is_load = 1; bus.e_rd = 5;
        bus.d_valid = 1; bus.d_rs1 = 5; bus.d_use_rs1 = 1;
        bus.e_branch_taken = 1; bus.icache_miss = 1;
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b0101_0001) begin
            n_fail++; $display("FAIL branch_over_loaduse: got %b want %b", ctrl_vec(), 8'b0101_0001);
        end
        step();
    endtask

    task automatic test_dcache_branch();
        clr();
        bus.dcache_miss = 1; bus.e_branch_taken = 1;
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b1010_1011) begin
            n_fail++; $display("FAIL dcache_over_branch: got %b want %b", ctrl_vec(), 8'b1010_1011);
        end
        step();
        bus.dcache_miss = 0;
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b0101_0001) begin
            n_fail++; $display("FAIL branch_after_miss: got %b want %b", ctrl_vec(), 8'b0101_0001);
        end
        step();
    endtask

    task automatic test_exception();
        clr();
        bus.w_exception = 1; bus.sb_empty = 0;
        #1;
        n_chk++;
        if (bus.exc_state !== 2'd0) begin
            n_fail++; $display("FAIL exc_entry_cycle: got %0d want 0", bus.exc_state);
        end
        step();
        bus.w_exception = 0;
        for (int i = 0; i < 3; i++) begin
            bus.sb_empty = (i == 2);
            #1;
            n_chk++;
            if (bus.exc_state !== 2'd1 || ctrl_vec() !== 8'b0101_0111) begin
                n_fail++; $display("FAIL drain_cycle%0d: got exc=%0d ctrl=%b want 1 %b",
                                   i, bus.exc_state, ctrl_vec(), 8'b0101_0111);
            end
            step();
        end
        #1;
        n_chk++;
        if (bus.exc_state !== 2'd2 || ctrl_vec() !== 8'b0100_0010) begin
            n_fail++; $display("FAIL redirect: got exc=%0d ctrl=%b want 2 %b", bus.exc_state, ctrl_vec(), 8'b0100_0010);
        end
        step();
        n_chk++;
        if (bus.exc_state !== 2'd0 || bus.pc_sel !== 2'd0) begin
            n_fail++; $display("FAIL exc_return: got exc=%0d pc=%0d want 0 0", bus.exc_state, bus.pc_sel);
        end
        // exception while a multiply is in flight
        bus.d_valid = 1; bus.d_is_mul = 1;
        step();
        bus.d_is_mul = 0; bus.w_exception = 1; bus.sb_empty = 0;
        step();
        bus.w_exception = 0;
        #1;
        n_chk++;
        if (bus.exc_state !== 2'd1 || bus.mul_busy !== 1'b0) begin
            n_fail++; $display("FAIL exc_kills_mul: got exc=%0d busy=%0b want 1 0", bus.exc_state, bus.mul_busy);
        end
        bus.sb_empty = 1;
        step();
        step();
    endtask

    task automatic test_reset_in_drain();
        clr();
        bus.w_exception = 1; bus.sb_empty = 0;
        step();
        bus.w_exception = 0;
        reset = 1;
        #1;
        n_chk++;
        if (ctrl_vec() !== 8'b0101_0111) begin
            n_fail++; $display("FAIL reset_in_drain_out: got %b want %b", ctrl_vec(), 8'b0101_0111);
        end
        step();
        reset = 0;
        #1;
        n_chk++;
        if (bus.exc_state !== 2'd0 || bus.mul_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_drain_state: got exc=%0d busy=%0b want 0 0", bus.exc_state, bus.mul_busy);
        end
        clr();
        step();
    endtask

    // Behavioural model: mode is 0 run / 1 draining / 2 redirecting, mul_left counts busy cycles.
    task automatic test_random();
        int mode, mul_left, bad;
        logic lu, ex_mul;
        logic [7:0] exp;
        logic [1:0] regs;
        mode = 0; mul_left = 0; bad = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 99) < 2);
            bus.d_valid = $urandom_range(0, 3) != 0;
            bus.d_is_mul = $urandom_range(0, 9) < 3;
            regs = 2'($urandom_range(0, 3)); bus.d_rs1 = {3'b0, regs};
            regs = 2'($urandom_range(0, 3)); bus.d_rs2 = {3'b0, regs};
            regs = 2'($urandom_range(0, 3)); bus.e_rd = {3'b0, regs};
            bus.d_use_rs1 = $urandom_range(0, 1); bus.d_use_rs2 = $urandom_range(0, 1);
            bus.e_valid = $urandom_range(0, 3) != 0; bus.e_is_load = $urandom_range(0, 1);
            bus.e_branch_taken = $urandom_range(0, 99) < 15;
            bus.icache_miss = $urandom_range(0, 99) < 20;
            bus.dcache_miss = $urandom_range(0, 99) < 15;
            bus.w_exception = $urandom_range(0, 99) < 4;
            bus.sb_empty = $urandom_range(0, 99) < 60;
            lu = bus.d_valid && bus.e_valid && bus.e_is_load && bus.e_rd != 0 &&
                 ((bus.d_use_rs1 && bus.d_rs1 == bus.e_rd) || (bus.d_use_rs2 && bus.d_rs2 == bus.e_rd));
            if (reset || mode == 1)        exp = 8'b0101_0111;
            else if (mode == 2)            exp = 8'b0100_0010;
            else if (bus.dcache_miss)      exp = 8'b1010_1011;
            else if (bus.e_branch_taken)   exp = 8'b0101_0001;
            else if (mul_left > 0)         exp = 8'b1010_0111;
            else if (lu)                   exp = 8'b1001_0011;
            else if (bus.icache_miss)      exp = 8'b0100_0011;
            else                           exp = 8'b0000_0000;
            #1;
            n_chk++;
            if (ctrl_vec() !== exp) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_ctrl cyc%0d: got %b want %b", cyc, ctrl_vec(), exp);
            end
            n_chk++;
            if (bus.exc_state !== 2'(mode) || bus.mul_busy !== (mul_left > 0)) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_state cyc%0d: got exc=%0d busy=%0b want %0d %0b",
                                       cyc, bus.exc_state, bus.mul_busy, mode, mul_left > 0);
            end
            ex_mul = bus.d_valid && bus.d_is_mul && !exp[7] && !exp[4];
            if (reset) begin
                mode = 0; mul_left = 0;
            end else if (mode == 1) begin
                mul_left = 0;
                if (bus.sb_empty && !bus.dcache_miss) mode = 2;
            end else if (mode == 2) begin
                mode = 0; mul_left = 0;
            end else if (bus.w_exception) begin
                mode = 1; mul_left = 0;
            end else if (!bus.dcache_miss) begin
                if (mul_left > 0) mul_left--;
                else if (ex_mul) mul_left = ML - 1;
            end
            step();
        end
        reset = 0; clr();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1; clr();
        test_reset();
        test_load_use();
        test_mul();
        test_branch_vs_loaduse();
        test_dcache_branch();
        test_exception();
        test_reset_in_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
